sample_window_buffer: RTL

//   Upstream feeder for the conv network: captures sample_in on each rising sample_clk edge into a

---
 rtl/sample_window_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sample_window_buffer.sv
// sample_window_buffer
//   Captures a signed sample on every rising edge of sample_clk into a circular
//   history RAM. It then gathers TAPS dilated history samples, newest first, and
//   presents them as one registered window over a valid/ready handshake.
//
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-low
//   sample_clk   level-toggling sample strobe, synchronous to clk
//   sample_in    signed sample, captured on a sample_clk rising edge
//   taps_out     tap k at [k*W +: W]; tap k is the sample k*DILATION samples ago
//   out_v        window valid, held until accepted
//   out_ready    consumer accepts the window when out_v && out_ready
//   fill         samples written since reset, saturating at DEPTH
//   overrun_cnt  windows replaced before acceptance, saturating at 255
module sample_window_buffer #(
  parameter int W        = 16,
  parameter int TAPS     = 4,
  parameter int DILATION = 1,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_clk,
  input  logic [W-1:0]             sample_in,
  output logic [TAPS*W-1:0]        taps_out,
  output logic                     out_v,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               overrun_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [PW:0]   FILL_MAX = (PW+1)'(DEPTH);
  localparam logic [KW-1:0] LAST_TAP = KW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, GATHER, PRESENT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                prev_sclk;
  logic                sclk_edge;
  logic                pending;
  logic [W-1:0]        hold;
  logic [PW-1:0]       wr_ptr;
  logic [KW-1:0]       gather_idx;
  logic [TAPS*W-1:0]   staging;
  logic [W-1:0]        ram [DEPTH];
  logic [PW-1:0]       rd_addr;
  logic [31:0]         tap_off;
  logic                tap_live;

  logic do_write;
  logic do_gather;
  logic do_present;
  logic set_pend;

  assign sclk_edge = sample_clk & ~prev_sclk;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an edge arriving in PRESENT itself counts as pending so
  // that sample is not stranded in the hold register.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sclk_edge) state_nxt = WRITE;
      WRITE:   state_nxt = GATHER;
      GATHER:  if (gather_idx == LAST_TAP) state_nxt = PRESENT;
      PRESENT: state_nxt = (pending || sclk_edge) ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    do_write   = (state == WRITE);
    do_gather  = (state == GATHER);
    do_present = (state == PRESENT);
    set_pend   = sclk_edge && (state != IDLE);
  end

  // Read address for the tap currently being gathered; taps reaching back past
  // the number of samples written so far read as zero.
  always_comb begin
    tap_off  = 32'(gather_idx) * 32'(DILATION);
    rd_addr  = wr_ptr - PW'(tap_off + 32'd1);
    tap_live = tap_off < 32'(fill);
  end

  // History RAM, not cleared by reset
  always_ff @(posedge clk) begin
    if (rst && do_write) ram[wr_ptr] <= hold;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_sclk   <= 1'b0;
      pending     <= 1'b0;
      hold        <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      gather_idx  <= '0;
      staging     <= '0;
      taps_out    <= '0;
      out_v       <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      prev_sclk <= sample_clk;
      if (sclk_edge) hold <= sample_in;

      if (do_present)    pending <= 1'b0;
      else if (set_pend) pending <= 1'b1;

      if (do_write) begin
        wr_ptr     <= wr_ptr + 1'b1;
        gather_idx <= '0;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end

      if (do_gather) begin
        staging[gather_idx*W +: W] <= tap_live ? ram[rd_addr] : '0;
        gather_idx <= gather_idx + 1'b1;
      end

      // A same-cycle accept consumes the old window, so it is not an overrun.
      if (do_present) begin
        taps_out <= staging;
        out_v    <= 1'b1;
        if (out_v && !out_ready && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 1'b1;
      end else if (out_v && out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

endmodule
